ft_module_nmr: RTL
==================

// Module: ft_module_nmr
// PURPOSE
//  Parametrised N-channel fault-tolerance checker/recovery unit for lockstep cores.
//  Compares per-channel register-file write bundles (we, addr, data) and PCs.
//  Majority-votes when NUM_CH>=3 and keeps a voted shadow register file.
//  On any disagreement, halts all cores, streams the shadow file back, restores the saved PC, then pulses resume.
// PARAMETERS
//  ADDR_WIDTH  5   register address width; DEPTH = 2**ADDR_WIDTH entries
//  DATA_WIDTH  32  register and PC width
//  NUM_CH      3   lockstep channels, 2..5 (2 = DMR rollback only, >=3 = voting)
//  CNT_WIDTH   8   width of saturating error counter
// PORTS
//  clk_i          in   1                    clock, rising edge
//  rst_i          in   1                    synchronous, active-high reset
//  we_i           in   NUM_CH               per-channel write enable
//  addr_i         in   NUM_CH*ADDR_WIDTH    per-channel write address, ch0 in LSBs
//  data_i         in   NUM_CH*DATA_WIDTH    per-channel write data, ch0 in LSBs
//  pc_i           in   NUM_CH*DATA_WIDTH    per-channel program counter
//  spc_o          out  DATA_WIDTH           saved (last agreed) PC
//  addr_o         out  ADDR_WIDTH           restore address
//  data_o         out  DATA_WIDTH           restore data
//  restore_we_o   out  1                    addr_o/data_o valid, cores write them
//  halt_o         out  1                    cores stalled
//  resume_o       out  1                    one-cycle pulse, cores reload spc_o
//  err_ch_o       out  NUM_CH               one-hot/multi-hot minority channels of last fault
//  err_cnt_o      out  CNT_WIDTH            faults detected since reset, saturating
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state RUN; shadow file, spc_o, addr_o, data_o, err_ch_o, err_cnt_o = 0.
//   restore_we_o, halt_o, resume_o = 0. Reset overrides any state, including mid-RESTORE.
//  Bundle of channel k: {we, addr, data, pc}. Channels agree iff bundles are bit-identical.
//   When we=0, addr/data are don't-care and excluded from the compare; pc is always compared.
//  States: RUN -> HALT -> RESTORE -> RESUME -> RUN.
//  RUN, all channels agree: if we=1, shadow[addr] <= data. spc_o <= pc. Both visible next cycle.
//  RUN, any disagreement (fault): goto HALT next edge; err_cnt_o++ (saturates at all-ones).
//   Vote: majority = bundle held by > NUM_CH/2 channels.
//   Majority exists: commit its write to shadow and its pc to spc_o (voted forward).
//    err_ch_o <= channels differing from the majority.
//   No majority (always true for NUM_CH=2 with a mismatch): no shadow write, spc_o held (rollback).
//    err_ch_o <= all-ones.
//  HALT: 1 cycle; halt_o=1; all inputs ignored.
//  RESTORE: DEPTH cycles, k = 0..DEPTH-1; halt_o=1, restore_we_o=1, addr_o=k, data_o=shadow[k].
//   addr_o wraps naturally; exit after k=DEPTH-1.
//  RESUME: 1 cycle; halt_o=1, resume_o=1, restore_we_o=0; spc_o stable.
//  Next cycle RUN: halt_o=0, resume_o=0.
//  Total stall per fault: DEPTH+2 cycles of halt_o, starting the cycle after the faulty bundle.
//  Inputs are ignored outside RUN; a fault during HALT/RESTORE/RESUME is not detected and not counted.
//  Outside RESTORE, addr_o/data_o hold their last values.
//  Register 0 is not special; it is written and restored like any entry.
// TESTING
//  1 Reset; 32 agreed writes addr=i, data=i*10, pc=0x80.
//    -> shadow[i]=i*10, spc_o=0x80, halt_o never 1, err_cnt_o=0.
//  2 NUM_CH=3; ch1 writes addr10 data101, ch0/ch2 data100.
//    -> err_ch_o=3'b010; halt_o 1 for 34 cycles; restore stream shows addr10=100 and addr i=i*10;
//       resume_o pulses once at the last of them; err_cnt_o=1.
//  3 NUM_CH=2; we={1,0} addr10 data100.
//    -> no shadow write; err_ch_o=2'b11; same 34-cycle sequence; spc_o unchanged (0x80).
//  4 NUM_CH=3; all three channels write different data to addr5.
//    -> rollback: shadow[5] keeps the old value, err_ch_o=3'b111.
//  5 rst_i asserted at RESTORE k=12.
//    -> next cycle all outputs 0, state RUN; an agreed write then lands normally.
//  6 Force 300 faults with CNT_WIDTH=8.
//    -> err_cnt_o saturates at 255; agreed pc mismatch alone also triggers a fault.

Source files
------------

// File: rtl/ft_module_nmr_if.sv
// Bus bundle between the lockstep cores and the fault-tolerance checker:
// per-channel write/PC inputs plus the restore, halt and error outputs.
interface ft_module_nmr_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int CNT_WIDTH  = 8
);
    logic [NUM_CH-1:0]            we_i;
    logic [NUM_CH*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_CH*DATA_WIDTH-1:0] data_i;
    logic [NUM_CH*DATA_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0]        spc_o;
    logic [ADDR_WIDTH-1:0]        addr_o;
    logic [DATA_WIDTH-1:0]        data_o;
    logic                         restore_we_o;
    logic                         halt_o;
    logic                         resume_o;
    logic [NUM_CH-1:0]            err_ch_o;
    logic [CNT_WIDTH-1:0]         err_cnt_o;

    modport master (
        output we_i, addr_i, data_i, pc_i,
        input  spc_o, addr_o, data_o, restore_we_o, halt_o, resume_o, err_ch_o, err_cnt_o
    );

    modport slave (
        input  we_i, addr_i, data_i, pc_i,
        output spc_o, addr_o, data_o, restore_we_o, halt_o, resume_o, err_ch_o, err_cnt_o
    );
endinterface

// File: rtl/ft_module_nmr.sv
// N-channel lockstep checker: votes per-channel write bundles into a shadow
// register file and, on any disagreement, halts, streams the file back and resumes.
module ft_module_nmr #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int CNT_WIDTH  = 8
) (
    input logic             clk_i,
    input logic             rst_i,
    ft_module_nmr_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BW    = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam int CW    = $clog2(NUM_CH + 1);
    localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALT    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_RESUME  = 2'd3
    } state_e;

    // addr/data are zeroed when we=0 so a plain vector compare ignores them
    function automatic logic [BW-1:0] mask_bundle(
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data,
        input logic [DATA_WIDTH-1:0] pc
    );
        logic [BW-1:0] b;
        if (we) begin
            b = {1'b1, addr, data, pc};
        end else begin
            b = {1'b0, {ADDR_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, pc};
        end
        return b;
    endfunction

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
    logic [DATA_WIDTH-1:0] shadow_d [DEPTH];
    logic [DATA_WIDTH-1:0] spc_q, spc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  restore_we_q, restore_we_d;
    logic                  halt_q, halt_d;
    logic                  resume_q, resume_d;
    logic [NUM_CH-1:0]     err_ch_q, err_ch_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic [BW-1:0]         bundle    [NUM_CH];
    logic [CW-1:0]         match_cnt [NUM_CH];
    logic [NUM_CH-1:0]     err_mask;
    logic [IW-1:0]         maj_idx;
    logic                  maj_found;
    logic                  all_agree;
    logic [BW-1:0]         maj_bundle;
    logic                  maj_we;
    logic [ADDR_WIDTH-1:0] maj_addr;
    logic [DATA_WIDTH-1:0] maj_data;
    logic [DATA_WIDTH-1:0] maj_pc;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Per-channel agreement counts, majority selection and minority mask
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            bundle[c] = mask_bundle(bus.we_i[c],
                                    bus.addr_i[c*ADDR_WIDTH +: ADDR_WIDTH],
                                    bus.data_i[c*DATA_WIDTH +: DATA_WIDTH],
                                    bus.pc_i[c*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            match_cnt[c] = {CW{1'b0}};
            for (int j = 0; j < NUM_CH; j++) begin
                match_cnt[c] = match_cnt[c] + ((bundle[j] == bundle[c]) ? CW'(1) : CW'(0));
            end
        end
        maj_found = 1'b0;
        maj_idx   = {IW{1'b0}};
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            maj_found = maj_found | (match_cnt[c] > CW'(NUM_CH / 2));
            maj_idx   = (match_cnt[c] > CW'(NUM_CH / 2)) ? IW'(c) : maj_idx;
        end
        all_agree  = (match_cnt[0] == CW'(NUM_CH));
        maj_bundle = bundle[maj_idx];
        {maj_we, maj_addr, maj_data, maj_pc} = maj_bundle;
        for (int c = 0; c < NUM_CH; c++) begin
            err_mask[c] = (bundle[c] != maj_bundle);
        end
        next_addr = addr_q + ADDR_WIDTH'(1);
    end

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        spc_d        = spc_q;
        addr_d       = addr_q;
        data_d       = data_q;
        restore_we_d = 1'b0;
        halt_d       = 1'b0;
        resume_d     = 1'b0;
        err_ch_d     = err_ch_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (maj_found) begin
                    spc_d = maj_pc;
                    if (maj_we) begin
                        shadow_d[maj_addr] = maj_data;
                    end else begin
                        shadow_d[maj_addr] = shadow_q[maj_addr];
                    end
                end else begin
                    spc_d = spc_q;
                end
                if (!all_agree) begin
                    state_d   = ST_HALT;
                    halt_d    = 1'b1;
                    err_ch_d  = maj_found ? err_mask : {NUM_CH{1'b1}};
                    err_cnt_d = (err_cnt_q == {CNT_WIDTH{1'b1}}) ? err_cnt_q
                                                                  : err_cnt_q + CNT_WIDTH'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d      = ST_RESTORE;
                halt_d       = 1'b1;
                restore_we_d = 1'b1;
                addr_d       = {ADDR_WIDTH{1'b0}};
                data_d       = shadow_q[0];
            end
            ST_RESTORE: begin
                halt_d = 1'b1;
                if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d  = ST_RESUME;
                    resume_d = 1'b1;
                end else begin
                    restore_we_d = 1'b1;
                    addr_d       = next_addr;
                    data_d       = shadow_q[next_addr];
                end
            end
            ST_RESUME: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RUN;
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= {DATA_WIDTH{1'b0}};
            end
            spc_q        <= {DATA_WIDTH{1'b0}};
            addr_q       <= {ADDR_WIDTH{1'b0}};
            data_q       <= {DATA_WIDTH{1'b0}};
            restore_we_q <= 1'b0;
            halt_q       <= 1'b0;
            resume_q     <= 1'b0;
            err_ch_q     <= {NUM_CH{1'b0}};
            err_cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            spc_q        <= spc_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            restore_we_q <= restore_we_d;
            halt_q       <= halt_d;
            resume_q     <= resume_d;
            err_ch_q     <= err_ch_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.spc_o        = spc_q;
    assign bus.addr_o       = addr_q;
    assign bus.data_o       = data_q;
    assign bus.restore_we_o = restore_we_q;
    assign bus.halt_o       = halt_q;
    assign bus.resume_o     = resume_q;
    assign bus.err_ch_o     = err_ch_q;
    assign bus.err_cnt_o    = err_cnt_q;
endmodule
